// File: rtl/fetch_pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_if
//   Bundles the three handshakes seen by the fetch PC controller:
//     cache     : ins_req/ins_addr out, ins_rdy/ins_data in
//     predictor : ask_predictor/now_ins_addr/jump_addr_to_pred/
//                 next_addr_to_pred out; jump/predictor_sgn_rdy/
//                 predictor_full/if_flush/addr_from_pred in
//     decoder   : ins_valid/ins_out/ins_pc_out out, dec_full in
//     JALR unit : jalr_resolved/jalr_target in
//   master = fetch controller side, slave = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface fetch_pc_ctrl_if;
    // cache
    logic        ins_req;
    logic [31:0] ins_addr;
    logic        ins_rdy;
    logic [31:0] ins_data;
    // branch predictor
    logic        ask_predictor;
    logic [31:0] now_ins_addr;
    logic [31:0] jump_addr_to_pred;
    logic [31:0] next_addr_to_pred;
    logic        jump;
    logic        predictor_sgn_rdy;
    logic        predictor_full;
    logic        if_flush;
    logic [31:0] addr_from_pred;
    // decoder
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc_out;
    logic        dec_full;
    // JALR target resolution
    logic        jalr_resolved;
    logic [31:0] jalr_target;

    modport master (
        output ins_req, ins_addr,
        output ask_predictor, now_ins_addr, jump_addr_to_pred, next_addr_to_pred,
        output ins_valid, ins_out, ins_pc_out,
        input  ins_rdy, ins_data,
        input  jump, predictor_sgn_rdy, predictor_full, if_flush, addr_from_pred,
        input  dec_full, jalr_resolved, jalr_target
    );

    modport slave (
        input  ins_req, ins_addr,
        input  ask_predictor, now_ins_addr, jump_addr_to_pred, next_addr_to_pred,
        input  ins_valid, ins_out, ins_pc_out,
        output ins_rdy, ins_data,
        output jump, predictor_sgn_rdy, predictor_full, if_flush, addr_from_pred,
        output dec_full, jalr_resolved, jalr_target
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl
//   Instruction-fetch PC controller. Fetches one instruction at a time,
//   classifies it, resolves JAL locally, asks the branch predictor about
//   conditional branches, stalls on JALR until its target arrives, and
//   redirects on a mispredict flush.
//   Ports:
//     clk  : clock
//     rst  : synchronous reset, active-low
//     rdy  : global ready; low freezes every register
//     bus  : fetch_pc_ctrl_if.master (cache, predictor, decoder, JALR)
// ---------------------------------------------------------------------------
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    fetch_pc_ctrl_if.master  bus
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH,
        DISPATCH,
        WAIT_PRED,
        HOLD_JALR,
        DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [31:0]         ir_reg, ir_next;
    logic                ins_req_reg, ins_req_next;
    logic                valid_reg, valid_next;
    logic                ask_reg, ask_next;
    logic [31:0]         ins_out_reg, ins_out_next;
    logic [ADDR_W-1:0]   ins_pc_reg, ins_pc_next;
    logic [ADDR_W-1:0]   now_addr_reg, now_addr_next;
    logic [ADDR_W-1:0]   jump_addr_reg, jump_addr_next;
    logic [ADDR_W-1:0]   next_addr_reg, next_addr_next;

    logic [6:0]          opcode;
    logic [ADDR_W-1:0]   imm_j;
    logic [ADDR_W-1:0]   imm_b;
    logic [ADDR_W-1:0]   pc_seq;

    assign opcode = ir_reg[6:0];
    assign imm_j  = {{12{ir_reg[31]}}, ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};
    assign imm_b  = {{20{ir_reg[31]}}, ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
    assign pc_seq = pc_reg + 32'd4;

    // Next-state / next-output logic
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        ir_next        = ir_reg;
        valid_next     = 1'b0;
        ask_next       = 1'b0;
        ins_out_next   = ins_out_reg;
        ins_pc_next    = ins_pc_reg;
        now_addr_next  = now_addr_reg;
        jump_addr_next = jump_addr_reg;
        next_addr_next = next_addr_reg;

        if (bus.if_flush) begin
            // Redirect wins over everything; nothing is emitted this cycle.
            pc_next = bus.addr_from_pred;
            case (state_reg)
                // A request still in flight must have its data swallowed.
                FETCH:   state_next = (ins_req_reg && !bus.ins_rdy) ? DRAIN : FETCH;
                DRAIN:   state_next = bus.ins_rdy ? FETCH : DRAIN;
                default: state_next = FETCH;
            endcase
        end else begin
            case (state_reg)
                FETCH: begin
                    if (ins_req_reg && bus.ins_rdy) begin
                        ir_next    = bus.ins_data;
                        state_next = DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (!bus.dec_full) begin
                        if (opcode == OP_BRANCH) begin
                            // Branch and its prediction request leave together,
                            // so a full predictor stalls the decoder hand-off too.
                            if (!bus.predictor_full) begin
                                valid_next     = 1'b1;
                                ask_next       = 1'b1;
                                ins_out_next   = ir_reg;
                                ins_pc_next    = pc_reg;
                                now_addr_next  = pc_reg;
                                jump_addr_next = pc_reg + imm_b;
                                next_addr_next = pc_seq;
                                state_next     = WAIT_PRED;
                            end
                        end else begin
                            valid_next   = 1'b1;
                            ins_out_next = ir_reg;
                            ins_pc_next  = pc_reg;
                            if (opcode == OP_JAL) begin
                                pc_next    = pc_reg + imm_j;
                                state_next = FETCH;
                            end else if (opcode == OP_JALR) begin
                                state_next = HOLD_JALR;
                            end else begin
                                pc_next    = pc_seq;
                                state_next = FETCH;
                            end
                        end
                    end
                end
                WAIT_PRED: begin
                    // Targets were captured when the question was asked.
                    if (bus.predictor_sgn_rdy) begin
                        pc_next    = bus.jump ? jump_addr_reg : next_addr_reg;
                        state_next = FETCH;
                    end
                end
                HOLD_JALR: begin
                    if (bus.jalr_resolved) begin
                        pc_next    = bus.jalr_target & ~32'h1;
                        state_next = FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.ins_rdy) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end

        // Request is registered so it stays low through reset and rises
        // together with the new PC on entry to FETCH.
        ins_req_next = (state_next == FETCH);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            ir_reg        <= '0;
            ins_req_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            ask_reg       <= 1'b0;
            ins_out_reg   <= '0;
            ins_pc_reg    <= '0;
            now_addr_reg  <= '0;
            jump_addr_reg <= '0;
            next_addr_reg <= '0;
        end else if (rdy) begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            ir_reg        <= ir_next;
            ins_req_reg   <= ins_req_next;
            valid_reg     <= valid_next;
            ask_reg       <= ask_next;
            ins_out_reg   <= ins_out_next;
            ins_pc_reg    <= ins_pc_next;
            now_addr_reg  <= now_addr_next;
            jump_addr_reg <= jump_addr_next;
            next_addr_reg <= next_addr_next;
        end
    end

    assign bus.ins_req           = ins_req_reg;
    assign bus.ins_addr          = pc_reg;
    // A pulse captured just before a freeze is held and shown once rdy returns.
    assign bus.ins_valid         = valid_reg & rdy;
    assign bus.ask_predictor     = ask_reg & rdy;
    assign bus.ins_out           = ins_out_reg;
    assign bus.ins_pc_out        = ins_pc_reg;
    assign bus.now_ins_addr      = now_addr_reg;
    assign bus.jump_addr_to_pred = jump_addr_reg;
    assign bus.next_addr_to_pred = next_addr_reg;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;
    logic clk;
    logic rst;
    logic rdy;
    int   total;
    int   bad;

    fetch_pc_ctrl_if bus();

    fetch_pc_ctrl #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        is_br;
        logic        is_jalr;
        logic        jump;
        logic [31:0] jalr_tgt;
        logic [31:0] exp_jt;
        logic [31:0] exp_nt;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [9];

    localparam logic [31:0] ALU  = 32'h00100093;  // addi x1,x0,1
    localparam logic [31:0] BEQ  = 32'h02000063;  // beq x0,x0,+0x20
    localparam logic [31:0] JALR = 32'h00008067;  // jalr x0,0(x1)

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (bus.ins_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.ins_req !== 1'b1) begin
            bad++;
            $display("FAIL %s: ins_req got %b expected 1 (timeout)", tag, bus.ins_req);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.ins_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.ins_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: ins_valid got %b expected 1 (timeout)", tag, bus.ins_valid);
        end
    endtask

    // Hand one instruction to the DUT at the current request.
    task automatic give_ins(input logic [31:0] ins);
        bus.ins_rdy  = 1'b1;
        bus.ins_data = ins;
        @(negedge clk);
        bus.ins_rdy  = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        wait_req($sformatf("v%0d_req", i));
        chk($sformatf("v%0d_fetch_addr", i), bus.ins_addr, v.pc);
        give_ins(v.ins);
        wait_valid($sformatf("v%0d_valid", i));
        chk($sformatf("v%0d_pc_out", i), bus.ins_pc_out, v.pc);
        chk($sformatf("v%0d_ins_out", i), bus.ins_out, v.ins);
        chk($sformatf("v%0d_ask", i), {31'b0, bus.ask_predictor}, {31'b0, v.is_br});
        if (v.is_br) begin
            chk($sformatf("v%0d_now_addr", i), bus.now_ins_addr, v.pc);
            chk($sformatf("v%0d_jump_addr", i), bus.jump_addr_to_pred, v.exp_jt);
            chk($sformatf("v%0d_next_addr", i), bus.next_addr_to_pred, v.exp_nt);
            bus.predictor_sgn_rdy = 1'b1;
            bus.jump              = v.jump;
        end
        if (v.is_jalr) begin
            bus.jalr_resolved = 1'b1;
            bus.jalr_target   = v.jalr_tgt;
        end
        @(negedge clk);
        bus.predictor_sgn_rdy = 1'b0;
        bus.jump              = 1'b0;
        bus.jalr_resolved     = 1'b0;
        chk($sformatf("v%0d_valid_width", i), {31'b0, bus.ins_valid}, 32'd0);
        chk($sformatf("v%0d_ask_width", i), {31'b0, bus.ask_predictor}, 32'd0);
        wait_req($sformatf("v%0d_next_req", i));
        chk($sformatf("v%0d_next_fetch", i), bus.ins_addr, v.exp_next);
        $display("txn %0d: pc=%h ins=%h next=%h", i, v.pc, v.ins, bus.ins_addr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{ALU,          32'h000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,   32'h004};
        vecs[1] = '{32'h00C0006F, 32'h004, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,   32'h010};
        vecs[2] = '{BEQ,          32'h010, 1'b1, 1'b0, 1'b1, 32'h0,   32'h030, 32'h014, 32'h030};
        vecs[3] = '{BEQ,          32'h030, 1'b1, 1'b0, 1'b0, 32'h0,   32'h050, 32'h034, 32'h034};
        vecs[4] = '{32'h0CC0006F, 32'h034, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,   32'h100};
        vecs[5] = '{32'hFF9FF06F, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,   32'h0F8};
        vecs[6] = '{JALR,         32'h0F8, 1'b0, 1'b1, 1'b0, 32'h205, 32'h0,   32'h0,   32'h204};
        vecs[7] = '{ALU,          32'h204, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,   32'h208};
        vecs[8] = '{32'hFE000CE3, 32'h208, 1'b1, 1'b0, 1'b1, 32'h0,   32'h200, 32'h20C, 32'h200};

        rst                   = 1'b0;
        rdy                   = 1'b1;
        bus.ins_rdy           = 1'b0;
        bus.ins_data          = '0;
        bus.jump              = 1'b0;
        bus.predictor_sgn_rdy = 1'b0;
        bus.predictor_full    = 1'b0;
        bus.if_flush          = 1'b0;
        bus.addr_from_pred    = '0;
        bus.dec_full          = 1'b0;
        bus.jalr_resolved     = 1'b0;
        bus.jalr_target       = '0;

        // Reset held two cycles: everything quiet.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_req", {31'b0, bus.ins_req}, 32'd0);
            chk("rst_valid", {31'b0, bus.ins_valid}, 32'd0);
            chk("rst_ask", {31'b0, bus.ask_predictor}, 32'd0);
            chk("rst_addr", bus.ins_addr, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'b0, bus.ins_req}, 32'd1);
        chk("post_rst_addr", bus.ins_addr, 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Branch at 0x200 held off by a full predictor for three decisions.
        wait_req("full_req");
        chk("full_fetch", bus.ins_addr, 32'h200);
        bus.predictor_full = 1'b1;
        give_ins(BEQ);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("full_valid_%0d", c), {31'b0, bus.ins_valid}, 32'd0);
            chk($sformatf("full_ask_%0d", c), {31'b0, bus.ask_predictor}, 32'd0);
        end
        bus.predictor_full = 1'b0;
        @(negedge clk);
        chk("full_ask_after", {31'b0, bus.ask_predictor}, 32'd1);
        chk("full_valid_after", {31'b0, bus.ins_valid}, 32'd1);
        chk("full_jump_addr", bus.jump_addr_to_pred, 32'h220);
        chk("full_next_addr", bus.next_addr_to_pred, 32'h204);
        bus.predictor_sgn_rdy = 1'b1;
        bus.jump              = 1'b0;
        @(negedge clk);
        bus.predictor_sgn_rdy = 1'b0;
        wait_req("full_next_req");
        chk("full_next_fetch", bus.ins_addr, 32'h204);
        $display("txn full: branch at 200 resolved not-taken");

        // Flush while a fetch is outstanding; late data must be dropped.
        bus.if_flush       = 1'b1;
        bus.addr_from_pred = 32'h400;
        @(negedge clk);
        bus.if_flush = 1'b0;
        chk("drain_req", {31'b0, bus.ins_req}, 32'd0);
        chk("drain_addr", bus.ins_addr, 32'h400);
        @(negedge clk);
        give_ins(ALU);
        chk("drain_done_req", {31'b0, bus.ins_req}, 32'd1);
        chk("drain_done_addr", bus.ins_addr, 32'h400);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("drain_no_valid_%0d", c), {31'b0, bus.ins_valid}, 32'd0);
            @(negedge clk);
        end
        $display("txn drain: stale fetch discarded, refetch at 400");

        // Flush coincident with the predictor's answer: flush target wins.
        give_ins(BEQ);
        wait_valid("wp_valid");
        chk("wp_ask", {31'b0, bus.ask_predictor}, 32'd1);
        chk("wp_jump_addr", bus.jump_addr_to_pred, 32'h420);
        bus.if_flush          = 1'b1;
        bus.addr_from_pred    = 32'h400;
        bus.predictor_sgn_rdy = 1'b1;
        bus.jump              = 1'b1;
        @(negedge clk);
        bus.if_flush          = 1'b0;
        bus.predictor_sgn_rdy = 1'b0;
        bus.jump              = 1'b0;
        chk("wp_flush_ask", {31'b0, bus.ask_predictor}, 32'd0);
        chk("wp_flush_valid", {31'b0, bus.ins_valid}, 32'd0);
        wait_req("wp_req");
        chk("wp_fetch", bus.ins_addr, 32'h400);
        $display("txn wait_pred flush: refetch at %h", bus.ins_addr);

        // Flush coincident with JALR resolution: flush target wins.
        give_ins(JALR);
        wait_valid("jf_valid");
        chk("jf_ask", {31'b0, bus.ask_predictor}, 32'd0);
        bus.if_flush       = 1'b1;
        bus.addr_from_pred = 32'h600;
        bus.jalr_resolved  = 1'b1;
        bus.jalr_target    = 32'h700;
        @(negedge clk);
        bus.if_flush      = 1'b0;
        bus.jalr_resolved = 1'b0;
        wait_req("jf_req");
        chk("jf_fetch", bus.ins_addr, 32'h600);
        $display("txn jalr flush: refetch at %h", bus.ins_addr);

        // Global freeze in DISPATCH delays the hand-off.
        give_ins(ALU);
        rdy = 1'b0;
        @(negedge clk);
        chk("frz_valid_0", {31'b0, bus.ins_valid}, 32'd0);
        @(negedge clk);
        chk("frz_valid_1", {31'b0, bus.ins_valid}, 32'd0);
        chk("frz_req", {31'b0, bus.ins_req}, 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        chk("frz_valid_after", {31'b0, bus.ins_valid}, 32'd1);
        chk("frz_pc_out", bus.ins_pc_out, 32'h600);
        wait_req("frz_next_req");
        chk("frz_next_fetch", bus.ins_addr, 32'h604);
        $display("txn freeze: alu at 600 dispatched after rdy");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
